instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 157 +++++++++++++++
 tb/tb_instr_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 32-bit words from instruction memory, decodes them
// onto register-file/ALU control fields and waits on the ALU when an op is enabled.
module instr_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  imem_addr,
    output logic        imem_rd,
    input  logic [31:0] imem_data,
    input  logic        alu_done,
    output logic [15:0] data_bus,
    output logic [4:0]  addr1,
    output logic        read,
    output logic        write,
    output logic        opcode_enable,
    output logic [3:0]  opcode,
    output logic [3:0]  flag_register,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        EXEC,
        WAIT_ALU,
        HALT
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  pc, pc_nx;
    logic [31:0] ir, ir_nx;
    logic        err_nx;

    logic        imem_rd_nx, read_nx, write_nx, opcode_enable_nx;
    logic        busy_nx, done_nx;
    logic [15:0] data_bus_nx;
    logic [4:0]  addr1_nx;
    logic [3:0]  opcode_nx, flag_register_nx;

    assign imem_addr = pc;

    // Outputs are decoded from the next state and next IR so that every output is a flop
    // and still lines up with the state it describes.
    always_comb begin
        state_nx         = state;
        pc_nx            = pc;
        ir_nx            = ir;
        err_nx           = err;
        imem_rd_nx       = 1'b0;
        read_nx          = 1'b0;
        write_nx         = 1'b0;
        opcode_enable_nx = 1'b0;
        busy_nx          = 1'b0;
        done_nx          = 1'b0;
        data_bus_nx      = 16'h0000;
        addr1_nx         = 5'h00;
        opcode_nx        = 4'h0;
        flag_register_nx = 4'h0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = FETCH;
                    err_nx   = 1'b0;
                end
            end
            FETCH: state_nx = LATCH;
            LATCH: begin
                ir_nx = imem_data;
                if (imem_data == 32'h0000_0000) begin
                    state_nx = HALT;
                end else begin
                    state_nx = EXEC;
                    if (imem_data[10] && imem_data[9]) err_nx = 1'b1;
                end
            end
            EXEC: begin
                if (!ir[8] || alu_done) begin
                    state_nx = FETCH;
                    pc_nx    = pc + 8'd1;
                end else begin
                    state_nx = WAIT_ALU;
                end
            end
            WAIT_ALU: begin
                if (alu_done) begin
                    state_nx = FETCH;
                    pc_nx    = pc + 8'd1;
                end
            end
            HALT: begin
                if (start) begin
                    state_nx = FETCH;
                    pc_nx    = pc + 8'd1;
                    err_nx   = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase

        imem_rd_nx = (state_nx == FETCH);
        busy_nx    = (state_nx == FETCH) || (state_nx == LATCH) ||
                     (state_nx == EXEC)  || (state_nx == WAIT_ALU);
        done_nx    = (state_nx == HALT);

        // Read and write together is illegal, so neither strobe is issued in that case.
        if (state_nx == EXEC || state_nx == WAIT_ALU) begin
            data_bus_nx      = ir_nx[31:16];
            addr1_nx         = ir_nx[15:11];
            opcode_enable_nx = ir_nx[8];
            opcode_nx        = ir_nx[7:4];
            flag_register_nx = ir_nx[3:0];
            if (state_nx == EXEC) begin
                read_nx  = ir_nx[10] & ~ir_nx[9];
                write_nx = ir_nx[9] & ~ir_nx[10];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= 8'h00;
            ir            <= 32'h0000_0000;
            err           <= 1'b0;
            imem_rd       <= 1'b0;
            read          <= 1'b0;
            write         <= 1'b0;
            opcode_enable <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            data_bus      <= 16'h0000;
            addr1         <= 5'h00;
            opcode        <= 4'h0;
            flag_register <= 4'h0;
        end else begin
            state         <= state_nx;
            pc            <= pc_nx;
            ir            <= ir_nx;
            err           <= err_nx;
            imem_rd       <= imem_rd_nx;
            read          <= read_nx;
            write         <= write_nx;
            opcode_enable <= opcode_enable_nx;
            busy          <= busy_nx;
            done          <= done_nx;
            data_bus      <= data_bus_nx;
            addr1         <= addr1_nx;
            opcode        <= opcode_nx;
            flag_register <= flag_register_nx;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer with a registered-read instruction memory.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [31:0] imem_data = 32'h0;
    logic        alu_done = 1'b0;
    logic [15:0] data_bus;
    logic [4:0]  addr1;
    logic        read, write, opcode_enable;
    logic [3:0]  opcode, flag_register;
    logic        busy, done, err;

    logic [31:0] mem [256];
    int          assert_count = 0;
    int          fail_count = 0;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
        .alu_done(alu_done), .data_bus(data_bus), .addr1(addr1),
        .read(read), .write(write), .opcode_enable(opcode_enable),
        .opcode(opcode), .flag_register(flag_register),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Memory returns the addressed word the cycle after the read strobe.
    always @(posedge clk) begin
        if (imem_rd) imem_data <= mem[imem_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a);
        start    = s;
        alu_done = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fillMem(input logic [31:0] word);
        for (int i = 0; i < 256; i++) mem[i] = word;
    endtask

    task automatic resetDut();
        applyStimulus(1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        fillMem(32'h0);

        // Reset values and basic register-read instruction timing
        mem[0] = 32'h1234_8400;
        resetDut();
        rst = 1'b1;
        tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_imem_rd", imem_rd, 0);
        checkOutput("rst_imem_addr", imem_addr, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_data_bus", data_bus, 0);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0);
        tick();
        checkOutput("c1_imem_rd", imem_rd, 1);
        checkOutput("c1_imem_addr", imem_addr, 0);
        checkOutput("c1_busy", busy, 1);
        applyStimulus(1'b0, 1'b0);
        tick();
        checkOutput("c2_imem_rd", imem_rd, 0);
        checkOutput("c2_read", read, 0);
        tick();
        checkOutput("c3_data_bus", data_bus, 16'h1234);
        checkOutput("c3_addr1", addr1, 5'h10);
        checkOutput("c3_read", read, 1);
        checkOutput("c3_write", write, 0);
        checkOutput("c3_opcode_enable", opcode_enable, 0);
        tick();
        checkOutput("c4_imem_rd", imem_rd, 1);
        checkOutput("c4_imem_addr", imem_addr, 1);
        checkOutput("c4_read", read, 0);
        checkOutput("c4_data_bus", data_bus, 0);
        tick();
        tick();
        checkOutput("halt1_done", done, 1);
        checkOutput("halt1_busy", busy, 0);

        // ALU instruction held in WAIT_ALU until alu_done
        fillMem(32'h0);
        mem[0] = 32'h0000_0153;
        resetDut();
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
        tick();
        tick();
        checkOutput("alu_exec_oe", opcode_enable, 1);
        checkOutput("alu_exec_opcode", opcode, 4'h5);
        checkOutput("alu_exec_flags", flag_register, 4'h3);
        for (int c = 4; c <= 6; c++) begin
            tick();
            checkOutput("alu_wait_oe", opcode_enable, 1);
            checkOutput("alu_wait_opcode", opcode, 4'h5);
            checkOutput("alu_wait_flags", flag_register, 4'h3);
            checkOutput("alu_wait_busy", busy, 1);
            checkOutput("alu_wait_imem_rd", imem_rd, 0);
        end
        applyStimulus(1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("alu_next_imem_rd", imem_rd, 1);
        checkOutput("alu_next_imem_addr", imem_addr, 1);
        checkOutput("alu_next_oe", opcode_enable, 0);

        // Illegal read+write instruction sets sticky err
        fillMem(32'h0);
        mem[0] = 32'hABCD_0600;
        mem[1] = 32'h0000_0010;
        resetDut();
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
        tick();
        tick();
        checkOutput("ill_err", err, 1);
        checkOutput("ill_read", read, 0);
        checkOutput("ill_write", write, 0);
        checkOutput("ill_data_bus", data_bus, 16'hABCD);
        tick();
        checkOutput("ill_next_addr", imem_addr, 1);
        checkOutput("ill_next_err", err, 1);
        tick();
        tick();
        checkOutput("ill_i1_opcode", opcode, 4'h1);
        checkOutput("ill_i1_err", err, 1);
        tick();
        tick();
        tick();
        checkOutput("ill_halt_done", done, 1);
        checkOutput("ill_halt_err", err, 1);
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("ill_restart_err", err, 0);
        checkOutput("ill_restart_addr", imem_addr, 3);

        // Three instructions then halt word; restart resumes after it
        fillMem(32'h0);
        mem[0] = 32'h0000_0001;
        mem[1] = 32'h0000_0200;
        mem[2] = 32'h0000_0001;
        mem[4] = 32'h0000_0001;
        resetDut();
        applyStimulus(1'b1, 1'b0);
        tick();
        tick();
        tick();
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("seq_fetch1_addr", imem_addr, 1);
        checkOutput("seq_fetch1_rd", imem_rd, 1);
        tick();
        tick();
        checkOutput("seq_i1_write", write, 1);
        checkOutput("seq_i1_read", read, 0);
        for (int c = 7; c <= 12; c++) tick();
        checkOutput("seq_halt_done", done, 1);
        checkOutput("seq_halt_addr", imem_addr, 3);
        checkOutput("seq_halt_busy", busy, 0);
        checkOutput("seq_halt_rd", imem_rd, 0);
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("seq_restart_addr", imem_addr, 4);
        checkOutput("seq_restart_rd", imem_rd, 1);
        checkOutput("seq_restart_done", done, 0);

        // Program counter wraps from 8'hFF to 8'h00
        fillMem(32'h0000_0001);
        resetDut();
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
        for (int k = 0; k <= 256; k++) begin
            checkOutput("wrap_fetch_addr", imem_addr, 32'(k % 256));
            tick();
            tick();
            tick();
        end

        // Asynchronous reset in WAIT_ALU abandons the ALU operation
        fillMem(32'h0);
        mem[0] = 32'h0000_0153;
        resetDut();
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("ar_wait_busy", busy, 1);
        checkOutput("ar_wait_oe", opcode_enable, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ar_busy", busy, 0);
        checkOutput("ar_oe", opcode_enable, 0);
        checkOutput("ar_opcode", opcode, 0);
        checkOutput("ar_flags", flag_register, 0);
        checkOutput("ar_imem_rd", imem_rd, 0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1);
        tick();
        checkOutput("ar_idle_busy", busy, 0);
        checkOutput("ar_idle_addr", imem_addr, 0);
        checkOutput("ar_idle_rd", imem_rd, 0);
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("ar_fetch_rd", imem_rd, 1);
        checkOutput("ar_fetch_addr", imem_addr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
